quad_encoder_position: RTL and testbench
========================================

// Module: quad_encoder_position
// PURPOSE
//  Quadrature (A/B) incremental-encoder interface producing an absolute 10-bit position.
//  Synchronises and deglitches the two asynchronous encoder phases and decodes them at x4 resolution.
//  Keeps a saturating up/down position counter.
//  Top-level block between external encoder pins and position consumers (e.g. a screen-coordinate user).
// PARAMETERS
//  WIDTH       10    width of coordinate output
//  FILTER_LEN  2     consecutive identical synced samples needed to accept a new phase level (>=1)
//  RESET_COORD 0     coordinate value loaded on reset
//  MIN_COORD   0     lower saturation bound
//  MAX_COORD   1023  upper saturation bound (<= 2**WIDTH-1)
// PORTS
//  clock       in   1      single system clock, rising edge
//  a_reset     in   1      asynchronous reset, active-high
//  encoder_a   in   1      encoder phase A, asynchronous to clock
//  encoder_b   in   1      encoder phase B, asynchronous to clock
//  coordinate  out  WIDTH  current position, registered
// BEHAVIOUR
//  Reset:
//   - a_reset high clears immediately, without a clock: synchronisers, filters, prev-state and primed flag to 0.
//   - coordinate = RESET_COORD while reset is held.
//  Synchroniser: 2-FF chain per phase (a_s, b_s).
//  Filter (per phase):
//   - The filtered level takes the a_s/b_s value once that value differs from the current filtered level.
//   - It must hold for FILTER_LEN consecutive clocks; any return to the filtered level restarts the count.
//   - A pulse shorter than FILTER_LEN clocks is discarded.
//  Decoder:
//   - Compares the current filtered {A,B} with the previous filtered {A,B}, one step per clock.
//   - Forward (+1) transitions: 00->10, 10->11, 11->01, 01->00 (A leads B).
//   - Reverse (-1) transitions: 00->01, 01->11, 11->10, 10->00.
//   - No change in {A,B}: hold.
//   - Both bits change in the same clock (00<->11, 10<->01): illegal; no count, prev-state updated.
//  Priming:
//   - The first filtered state after reset release is adopted as prev-state without counting.
//   - Pins non-zero at reset release therefore never cause a spurious step.
//  Counter:
//   - coordinate += 1 on forward and -= 1 on reverse.
//   - Saturates: holds at MAX_COORD on forward and at MIN_COORD on reverse; never wraps.
//  Latency: a pin edge changes coordinate exactly 3+FILTER_LEN rising clock edges after the first edge that samples it.
//   - At defaults this is 5 clocks; constant for all legal transitions.
//  Max rate: one count per FILTER_LEN clocks; faster pin activity is filtered, not miscounted.
//  Reset mid-operation: coordinate returns to RESET_COORD at once.
//   - Counting resumes from the first legal step after re-priming.
// TESTING
//  (10 ns clock; each encoder level held 20 ns unless stated)
//  T1 reset: hold a_reset high, toggle pins -> coordinate=0; assert a_reset mid-count at 37 -> 0 before next clock edge.
//  T2 forward: 00->10->11->01->00 repeated 10 cycles -> coordinate=40, +1 per step, first change 5 clocks after first edge.
//  T3 reverse: from 40, 01->11->10->00 ordering for 5 cycles -> coordinate=20.
//  T4 glitch: 1-clock pulse on encoder_a (FILTER_LEN=2) -> coordinate unchanged.
//  T4 glitch: 2-clock pulse -> +1 then -1.
//  T5 illegal: filtered {A,B} 00->11 in one step -> no count; next 11->01 -> +1.
//  T6 saturation: RESET_COORD=1022, 3 forward steps -> 1023 held.
//  T6 saturation: from 0, reverse steps -> stays 0.
//  T6 priming: pins at 11 during reset release -> coordinate stays 0.

Source files
------------

// File: rtl/quad_encoder_position.sv
// Quadrature A/B encoder front end: 2-FF synchronisers, per-phase persistence filters,
// x4 decoder with start-up priming, and a saturating up/down position counter.
module quad_encoder_position #(
  parameter int WIDTH       = 10,
  parameter int FILTER_LEN  = 2,
  parameter int RESET_COORD = 0,
  parameter int MIN_COORD   = 0,
  parameter int MAX_COORD   = 1023
) (
  input  logic             clock,
  input  logic             a_reset,
  input  logic             encoder_a,
  input  logic             encoder_b,
  output logic [WIDTH-1:0] coordinate
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(FILTER_LEN - 1);
  localparam logic [WIDTH-1:0] RST_C    = WIDTH'(RESET_COORD);
  localparam logic [WIDTH-1:0] MIN_C    = WIDTH'(MIN_COORD);
  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_COORD);

  // Bit 1 carries phase A, bit 0 carries phase B throughout.
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       filt_q, filt_d;
  logic [CW-1:0]    cnt_q [2];
  logic [CW-1:0]    cnt_d [2];
  logic [1:0]       prev_q;
  logic [1:0]       warm_q, warm_d;
  logic             primed_q, primed_d;
  logic [WIDTH-1:0] coord_q, coord_d;
  logic             step_fwd, step_rev, settled;

  always_ff @(posedge clock or posedge a_reset) begin
    if (a_reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {encoder_a, encoder_b};
      sync2_q <= sync1_q;
    end
  end

  // A new level is accepted only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = CW'(cnt_q[i] + 1'b1);
      end
    end
  end

  always_comb begin
    step_fwd = 1'b0;
    step_rev = 1'b0;
    case ({prev_q, filt_q})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_fwd = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_rev = 1'b1;
      default: ;
    endcase
  end

  // Priming waits for the synchronisers to fill and the filters to match the pins,
  // so whatever level the encoder rests at on release is adopted silently.
  assign settled = (sync2_q == filt_q);

  always_comb begin
    warm_d   = warm_q;
    primed_d = primed_q;
    if (!primed_q) begin
      if (warm_q != 2'd2) begin
        warm_d = warm_q + 2'd1;
      end else if (settled) begin
        primed_d = 1'b1;
      end
    end
  end

  always_comb begin
    coord_d = coord_q;
    if (primed_q) begin
      if (step_fwd && (coord_q < MAX_C)) begin
        coord_d = coord_q + 1'b1;
      end else if (step_rev && (coord_q > MIN_C)) begin
        coord_d = coord_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge a_reset) begin
    if (a_reset) begin
      filt_q   <= 2'b00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      prev_q   <= 2'b00;
      warm_q   <= 2'd0;
      primed_q <= 1'b0;
      coord_q  <= RST_C;
    end else begin
      filt_q   <= filt_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      prev_q   <= filt_q;
      warm_q   <= warm_d;
      primed_q <= primed_d;
      coord_q  <= coord_d;
    end
  end

  assign coordinate = coord_q;

endmodule

// File: tb/tb_quad_encoder_position.sv
// Directed bench for quad_encoder_position: default instance plus one reset at 1022
// to exercise upper saturation with the same pin activity.
module tb_quad_encoder_position;

  logic       clock = 1'b0;
  logic       a_reset = 1'b1;
  logic       encoder_a = 1'b0;
  logic       encoder_b = 1'b0;
  logic [9:0] coord0, coord1;
  int         checks = 0;
  int         failures = 0;

  always #5 clock = ~clock;

  quad_encoder_position dut0 (
    .clock(clock), .a_reset(a_reset), .encoder_a(encoder_a),
    .encoder_b(encoder_b), .coordinate(coord0)
  );

  quad_encoder_position #(.RESET_COORD(1022)) dut1 (
    .clock(clock), .a_reset(a_reset), .encoder_a(encoder_a),
    .encoder_b(encoder_b), .coordinate(coord1)
  );

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; holds the new level for n clocks and returns at a negedge.
  task automatic set_pins(input logic a, input logic b, input int n);
    encoder_a = a;
    encoder_b = b;
    repeat (n) @(negedge clock);
  endtask

  task automatic fwd_cycle();
    set_pins(1'b1, 1'b0, 2);
    set_pins(1'b1, 1'b1, 2);
    set_pins(1'b0, 1'b1, 2);
    set_pins(1'b0, 1'b0, 2);
  endtask

  task automatic rev_cycle();
    set_pins(1'b0, 1'b1, 2);
    set_pins(1'b1, 1'b1, 2);
    set_pins(1'b1, 1'b0, 2);
    set_pins(1'b0, 1'b0, 2);
  endtask

  task automatic settle();
    repeat (8) @(negedge clock);
  endtask

  initial begin
    // Reset held while pins toggle.
    @(negedge clock);
    set_pins(1'b1, 1'b0, 1);
    set_pins(1'b1, 1'b1, 1);
    set_pins(1'b0, 1'b1, 1);
    check("reset_hold_d0", coord0, 10'd0);
    check("reset_hold_d1", coord1, 10'd1022);
    set_pins(1'b0, 1'b0, 2);
    a_reset = 1'b0;
    repeat (6) @(negedge clock);
    check("released_d0", coord0, 10'd0);

    // First forward step: 5-clock latency from the first sampling edge.
    encoder_a = 1'b1;
    repeat (4) @(posedge clock);
    #1 check("latency_e4", coord0, 10'd0);
    @(posedge clock);
    #1 check("latency_e5", coord0, 10'd1);
    check("sat_hi_first", coord1, 10'd1023);
    @(negedge clock);
    set_pins(1'b1, 1'b1, 2);
    set_pins(1'b0, 1'b1, 2);
    set_pins(1'b0, 1'b0, 2);
    settle();
    check("fwd_one_cycle", coord0, 10'd4);
    check("sat_hi_held", coord1, 10'd1023);
    for (int i = 0; i < 9; i++) fwd_cycle();
    settle();
    check("fwd_ten_cycles", coord0, 10'd40);

    // Reverse 5 cycles.
    for (int i = 0; i < 5; i++) rev_cycle();
    settle();
    check("rev_five_d0", coord0, 10'd20);
    check("rev_five_d1", coord1, 10'd1003);

    // One-clock glitch on A is discarded.
    set_pins(1'b1, 1'b0, 1);
    set_pins(1'b0, 1'b0, 1);
    settle();
    check("glitch_1clk", coord0, 10'd20);

    // Two-clock pulse: +1 then -1.
    encoder_a = 1'b1;
    repeat (2) @(negedge clock);
    encoder_a = 1'b0;
    repeat (3) @(posedge clock);
    #1 check("pulse2_up_d0", coord0, 10'd21);
    check("pulse2_up_d1", coord1, 10'd1004);
    repeat (3) @(posedge clock);
    #1 check("pulse2_down", coord0, 10'd20);
    @(negedge clock);
    settle();

    // Illegal 00->11, then legal forward steps.
    set_pins(1'b1, 1'b1, 4);
    settle();
    check("illegal_00_11", coord0, 10'd20);
    set_pins(1'b0, 1'b1, 2);
    settle();
    check("after_illegal", coord0, 10'd21);
    set_pins(1'b0, 1'b0, 2);
    settle();
    check("back_to_00_d0", coord0, 10'd22);
    check("back_to_00_d1", coord1, 10'd1005);

    // Count up to 37 then reset asynchronously mid-clock.
    for (int i = 0; i < 3; i++) fwd_cycle();
    set_pins(1'b1, 1'b0, 2);
    set_pins(1'b1, 1'b1, 2);
    set_pins(1'b0, 1'b1, 2);
    settle();
    check("count_37_d0", coord0, 10'd37);
    check("count_37_d1", coord1, 10'd1020);
    @(posedge clock);
    #2 a_reset = 1'b1;
    #1 check("async_reset_d0", coord0, 10'd0);
    check("async_reset_d1", coord1, 10'd1022);

    // Priming: pins at 11 across reset release.
    @(negedge clock);
    set_pins(1'b1, 1'b1, 3);
    a_reset = 1'b0;
    repeat (10) @(negedge clock);
    check("prime_11_d0", coord0, 10'd0);
    check("prime_11_d1", coord1, 10'd1022);
    set_pins(1'b0, 1'b1, 2);
    settle();
    check("resume_d0", coord0, 10'd1);
    check("resume_d1", coord1, 10'd1023);

    // Lower saturation.
    set_pins(1'b1, 1'b1, 2);
    set_pins(1'b1, 1'b0, 2);
    set_pins(1'b0, 1'b0, 2);
    settle();
    check("sat_lo_d0", coord0, 10'd0);
    check("sat_lo_d1", coord1, 10'd1020);
    rev_cycle();
    settle();
    check("sat_lo_held", coord0, 10'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
